// File: rtl/weight_pkg.sv
// Shared types and elaboration helpers for the runtime weight loader.
package weight_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

    // Number of stream beats that make up one stored word.
    function automatic int unsigned beats(input int unsigned data_width,
                                          input int unsigned in_width);
        return data_width / in_width;
    endfunction

    function automatic bit width_ok(input int unsigned data_width,
                                    input int unsigned in_width);
        return (in_width != 0) && ((data_width % in_width) == 0);
    endfunction

endpackage

// File: rtl/weight_ram.sv
// Simple dual-port weight memory: one write port, one registered read port.
module weight_ram #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned DEPTH      = 10,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] dout_q;

    // Contents are deliberately not reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-first: a same-address write lands after this sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else begin
            dout_q <= mem[raddr];
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/weight_loader.sv
// Packs a narrow valid/ready byte stream into words and writes them to
// consecutive weight-memory addresses; independent 1-cycle read port.
module weight_loader
    import weight_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 24,
    parameter int unsigned NUM_WEIGHTS = 10,
    parameter int unsigned IN_WIDTH    = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               load_start,
    input  logic                               load_abort,
    input  logic                               s_valid,
    input  logic [IN_WIDTH-1:0]                s_data,
    output logic                               s_ready,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(NUM_WEIGHTS+1)-1:0]   word_count,
    input  logic [$clog2(NUM_WEIGHTS)-1:0]     addr,
    output logic [DATA_WIDTH-1:0]              dout
);

    localparam int unsigned BEATS = beats(DATA_WIDTH, IN_WIDTH);
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned AW    = $clog2(NUM_WEIGHTS);
    localparam int unsigned CW    = $clog2(NUM_WEIGHTS + 1);

    if (!width_ok(DATA_WIDTH, IN_WIDTH)) begin : g_width_chk
        $error("weight_loader: DATA_WIDTH must be a multiple of IN_WIDTH");
    end

    loader_state_t         state_q, state_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic [AW-1:0]         waddr_q, waddr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] asm_q, asm_d;
    logic [DATA_WIDTH-1:0] asm_shift_c;
    logic                  we_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            waddr_q <= '0;
            cnt_q   <= '0;
            asm_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            waddr_q <= waddr_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
        end
    end

    // Little-endian packing: each new beat enters at the top and earlier beats
    // shift down, so after BEATS beats the first one sits in the low bits.
    assign asm_shift_c = (asm_q >> IN_WIDTH)
                       | (DATA_WIDTH'(s_data) << (DATA_WIDTH - IN_WIDTH));

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        waddr_d = waddr_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        we_c    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD;
                    beat_d  = '0;
                    waddr_d = '0;
                    cnt_d   = '0;
                    asm_d   = '0;
                end
            end
            LOAD: begin
                if (load_abort) begin
                    state_d = IDLE;
                    beat_d  = '0;
                    asm_d   = '0;
                end else if (s_valid) begin
                    asm_d = asm_shift_c;
                    if (beat_q == BW'(BEATS - 1)) begin
                        we_c    = 1'b1;
                        beat_d  = '0;
                        waddr_d = waddr_q + AW'(1);
                        cnt_d   = cnt_q + CW'(1);
                        if (waddr_q == AW'(NUM_WEIGHTS - 1)) begin
                            state_d = DONE;
                        end
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // An abort blocks the beat presented in the same cycle.
    assign s_ready    = (state_q == LOAD) && !load_abort;
    assign busy       = (state_q == LOAD);
    assign done       = (state_q == DONE);
    assign word_count = cnt_q;

    weight_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (NUM_WEIGHTS),
        .ADDR_WIDTH (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we_c),
        .waddr (waddr_q),
        .wdata (asm_shift_c),
        .raddr (addr),
        .dout  (dout)
    );

endmodule

// File: tb/tb_weight_loader.sv
// Directed + randomized bench for weight_loader against a word-level memory model.
module tb_weight_loader;

    localparam int unsigned DW    = 24;
    localparam int unsigned NW    = 10;
    localparam int unsigned IW    = 8;
    localparam int unsigned NBEAT = DW / IW;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic          load_abort;
    logic          s_valid;
    logic [IW-1:0] s_data;
    logic          s_ready;
    logic          busy;
    logic          done;
    logic [3:0]    word_count;
    logic [3:0]    addr;
    logic [DW-1:0] dout;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] stim_words [NW];
    logic [DW-1:0] model_mem  [NW];

    weight_loader #(
        .DATA_WIDTH  (DW),
        .NUM_WEIGHTS (NW),
        .IN_WIDTH    (IW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_abort (load_abort),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .busy       (busy),
        .done       (done),
        .word_count (word_count),
        .addr       (addr),
        .dout       (dout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [IW-1:0] beat_of(input int b);
        logic [DW-1:0] w;
        w = stim_words[b / NBEAT];
        return IW'(w >> (IW * (b % NBEAT)));
    endfunction

    task automatic spec_words();
        for (int k = 0; k < NW; k++)
            stim_words[k] = 24'hC01000 + DW'(k * 32'h100) + DW'(k);
    endtask

    task automatic rand_words();
        for (int k = 0; k < NW; k++)
            stim_words[k] = DW'($urandom);
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < NW; i++) begin
            addr = 4'(i);
            tick();
            chk($sformatf("%s_mem%0d", tag, i), 32'(dout), 32'(model_mem[i]));
        end
    endtask

    // mode 0: back-to-back, 1: valid low every third cycle, 2: random bubbles.
    // rdw_addr >= 0 checks old-then-new read data at that address across its write.
    task automatic run_load(input int mode, input int rdw_addr, input bit with_abort);
        int beat;
        int cycles;
        int pending;
        bit v;
        load_start = 1'b1;
        load_abort = with_abort;
        s_valid    = 1'b0;
        tick();
        load_start = 1'b0;
        load_abort = 1'b0;
        beat    = 0;
        cycles  = 0;
        pending = -1;
        while (beat < NW * NBEAT && cycles < 300) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cycles % 3) != 2;
                default: v = $urandom_range(0, 3) != 0;
            endcase
            s_valid = v;
            s_data  = v ? beat_of(beat) : IW'($urandom);
            #1;
            if (cycles < 2 || v == 1'b0) begin
                chk("load_ready", 32'(s_ready), 32'd1);
                chk("load_busy", 32'(busy), 32'd1);
            end
            chk("load_done_low", 32'(done), 32'd0);
            tick();
            cycles++;
            if (pending >= 0) begin
                chk("rdw_new", 32'(dout), 32'(stim_words[pending]));
                pending = -1;
            end
            if (v) begin
                beat++;
                if (beat % NBEAT == 0) begin
                    if (beat / NBEAT - 1 == rdw_addr) begin
                        chk("rdw_old", 32'(dout), 32'(model_mem[rdw_addr]));
                        pending = rdw_addr;
                    end
                    model_mem[beat / NBEAT - 1] = stim_words[beat / NBEAT - 1];
                end
            end
        end
        s_valid = 1'b0;
        chk("load_beats", 32'(beat), 32'(NW * NBEAT));
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_ready", 32'(s_ready), 32'd0);
        chk("done_count", 32'(word_count), 32'(NW));
        tick();
        chk("done_single", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_count", 32'(word_count), 32'(NW));
        if (pending >= 0)
            chk("rdw_new_end", 32'(dout), 32'(stim_words[pending]));
    endtask

    initial begin
        rst        = 1'b1;
        load_start = 1'b0;
        load_abort = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        addr       = '0;

        // Reset state
        tick();
        tick();
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(word_count), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_ready", 32'(s_ready), 32'd0);

        // Full back-to-back load with the reference pattern
        spec_words();
        run_load(0, -1, 1'b0);
        addr = 4'd3;
        tick();
        chk("addr3_word", 32'(dout), 32'hC01303);
        check_mem("full");

        // Bubbled stream, same data
        run_load(1, -1, 1'b0);
        check_mem("bubble");

        // Random data, random bubbles; start and abort together from IDLE
        rand_words();
        run_load(2, -1, 1'b1);
        check_mem("rand");

        // Abort after 4 accepted beats
        rand_words();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int b = 0; b < 4; b++) begin
            s_valid = 1'b1;
            s_data  = beat_of(b);
            tick();
        end
        model_mem[0] = stim_words[0];
        load_abort = 1'b1;
        s_valid    = 1'b1;
        s_data     = beat_of(4);
        #1;
        chk("abort_ready", 32'(s_ready), 32'd0);
        tick();
        load_abort = 1'b0;
        s_valid    = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_count", 32'(word_count), 32'd1);
        check_mem("abort");
        rand_words();
        run_load(2, -1, 1'b0);
        check_mem("reload");

        // Reset mid-load after 7 beats
        rand_words();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int b = 0; b < 7; b++) begin
            s_valid = 1'b1;
            s_data  = beat_of(b);
            tick();
        end
        model_mem[0] = stim_words[0];
        model_mem[1] = stim_words[1];
        rst = 1'b1;
        tick();
        chk("mrst_ready", 32'(s_ready), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_count", 32'(word_count), 32'd0);
        chk("mrst_dout", 32'(dout), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            s_data = IW'($urandom);
            #1;
            chk("mrst_noaccept", 32'(s_ready), 32'd0);
            tick();
            chk("mrst_idle", 32'(busy), 32'd0);
        end
        s_valid = 1'b0;
        check_mem("mrst");

        // Read-during-write at address 2
        rand_words();
        stim_words[2] = 24'hABCDEF;
        run_load(0, -1, 1'b0);
        check_mem("pre_rdw");
        spec_words();
        addr = 4'd2;
        tick();
        chk("rdw_pre", 32'(dout), 32'hABCDEF);
        run_load(0, 2, 1'b0);
        check_mem("post_rdw");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
